// File: rtl/dma_pkg.sv
// ---------------------------------------------------------------------------
// dma_pkg
// Shared definitions for the multi-channel DMA controller:
//   - engine_state_t : states of the shared transfer engine
//   - OFF_*          : per-channel register offsets within a channel window
//   - CH_STRIDE      : byte distance between channel windows
//   - STATUS_ADDR    : byte address of the global STATUS register
//   - CTRL_*_BIT     : bit positions inside a channel CTRL register
// ---------------------------------------------------------------------------
package dma_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        NEXT
    } engine_state_t;

    localparam logic [3:0] OFF_CTRL = 4'h0;
    localparam logic [3:0] OFF_SRC  = 4'h4;
    localparam logic [3:0] OFF_DST  = 4'h8;
    localparam logic [3:0] OFF_LEN  = 4'hC;

    localparam int CH_STRIDE   = 'h10;
    localparam int STATUS_ADDR = 'h80;

    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;

    // Bit position of DONE[0] inside STATUS; BUSY starts at bit 0.
    localparam int STATUS_DONE_LSB = 8;

endpackage

// File: rtl/dma_rr_arb.sv
// ---------------------------------------------------------------------------
// dma_rr_arb
// Round-robin arbiter for the DMA channels. The search for a requester
// starts at the channel after the one accepted last; after reset it starts
// at channel 0.
//
// Ports:
//   clk    in  1       rising-edge clock
//   rst_n  in  1       synchronous active-low reset (clears the pointer)
//   req    in  NUM_CH  request vector (one bit per channel)
//   accept in  1       current grant is taken; advance the pointer past it
//   grant  out NUM_CH  one-hot grant (all zero when no request)
// ---------------------------------------------------------------------------
module dma_rr_arb #(
    parameter int NUM_CH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    input  logic              accept,
    output logic [NUM_CH-1:0] grant
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] grant_idx;

    // Scan all channels starting at ptr; the first requester wins.
    always_comb begin
        int  c;
        logic found;
        c         = 0;
        found     = 1'b0;
        grant     = '0;
        grant_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            c = (int'(ptr) + i) % NUM_CH;
            if (!found && req[c]) begin
                grant[c]  = 1'b1;
                grant_idx = IDX_W'(c);
                found     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (accept && (|grant)) begin
            if (int'(grant_idx) == NUM_CH - 1) begin
                ptr <= '0;
            end else begin
                ptr <= grant_idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/dma_multi_ch_ctrl.sv
// ---------------------------------------------------------------------------
// dma_multi_ch_ctrl
// Multi-channel memory-to-memory DMA controller with one shared engine.
// Each channel has CTRL/SRC/DST/LEN registers at ch*0x10; STATUS at 0x80
// reports DONE (bits 15:8) and BUSY (bits 7:0). The engine picks a BUSY
// channel round-robin, copies LEN words one read/one write at a time, then
// marks the channel DONE.
//
// Ports:
//   clk, rst_n                 clock / synchronous active-low reset
//   wr_en, rd_en, addr, wdata  register bus (write takes effect on the edge,
//                              read data appears in rdata one cycle later)
//   rdata                      registered read data, holds between reads
//   mem_req, mem_we, mem_addr,
//   mem_wdata                  memory request (held while not granted)
//   mem_gnt, mem_rvalid,
//   mem_rdata                  memory grant and read return
//   irq                        registered OR of DONE & IRQ_EN
// ---------------------------------------------------------------------------
module dma_multi_ch_ctrl
    import dma_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_AW     = 32,
    parameter int NUM_CH     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [MEM_AW-1:0]     mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  irq
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int STEP  = DATA_WIDTH / 8;

    // Zero-extend or truncate between register width and memory address width.
    function automatic logic [MEM_AW-1:0] to_mem(input logic [DATA_WIDTH-1:0] d);
        logic [MEM_AW+DATA_WIDTH-1:0] t;
        t = {{MEM_AW{1'b0}}, d};
        return t[MEM_AW-1:0];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] to_data(input logic [MEM_AW-1:0] a);
        logic [MEM_AW+DATA_WIDTH-1:0] t;
        t = {{DATA_WIDTH{1'b0}}, a};
        return t[DATA_WIDTH-1:0];
    endfunction

    // Channel register file
    logic [MEM_AW-1:0]     src_r [NUM_CH];
    logic [MEM_AW-1:0]     dst_r [NUM_CH];
    logic [DATA_WIDTH-1:0] len_r [NUM_CH];
    logic [NUM_CH-1:0]     irq_en;
    logic [NUM_CH-1:0]     busy;
    logic [NUM_CH-1:0]     done;

    // Engine state
    engine_state_t         state;
    logic [IDX_W-1:0]      cur_ch;
    logic [MEM_AW-1:0]     cur_src;
    logic [MEM_AW-1:0]     cur_dst;
    logic [DATA_WIDTH-1:0] rem;

    // Address decode
    logic [2:0]            addr_ch;
    logic [3:0]            addr_off;
    logic [IDX_W-1:0]      wch;
    logic                  ch_hit;
    logic                  status_hit;
    logic [DATA_WIDTH-1:0] rd_val;

    assign addr_ch    = addr[6:4];
    assign addr_off   = addr[3:0];
    assign wch        = addr_ch[IDX_W-1:0];
    assign ch_hit     = ((addr >> 7) == '0) && (int'(addr_ch) < NUM_CH);
    assign status_hit = (addr == ADDR_WIDTH'(STATUS_ADDR));

    always_comb begin
        rd_val = '0;
        if (status_hit) begin
            rd_val[NUM_CH-1:0]                 = busy;
            rd_val[STATUS_DONE_LSB +: NUM_CH]  = done;
        end else if (ch_hit) begin
            case (addr_off)
                OFF_CTRL: rd_val[CTRL_IRQ_EN_BIT] = irq_en[wch];
                OFF_SRC:  rd_val = to_data(src_r[wch]);
                OFF_DST:  rd_val = to_data(dst_r[wch]);
                OFF_LEN:  rd_val = len_r[wch];
                default:  rd_val = '0;
            endcase
        end
    end

    // Arbitration
    logic [NUM_CH-1:0] grant;
    logic [IDX_W-1:0]  gnt_idx;
    logic              accept;

    assign accept = (state == ARB) && (|busy);

    dma_rr_arb #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (busy),
        .accept (accept),
        .grant  (grant)
    );

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                gnt_idx = IDX_W'(i);
            end
        end
    end

    // Channel completes in NEXT when this was its last word (or LEN was 0).
    logic rem_last;
    logic fin;

    assign rem_last = (rem == '0) || (rem == DATA_WIDTH'(1));
    assign fin      = (state == NEXT) && rem_last;

    // Register file, BUSY/DONE and read data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                src_r[i] <= '0;
                dst_r[i] <= '0;
                len_r[i] <= '0;
            end
            irq_en <= '0;
            busy   <= '0;
            done   <= '0;
            rdata  <= '0;
        end else begin
            // rd_val is built from pre-edge state, so a same-cycle write
            // is not visible in this read.
            if (rd_en) begin
                rdata <= rd_val;
            end
            if (wr_en && ch_hit) begin
                case (addr_off)
                    OFF_CTRL: begin
                        irq_en[wch] <= wdata[CTRL_IRQ_EN_BIT];
                        if (wdata[CTRL_START_BIT] && !busy[wch]) begin
                            busy[wch] <= 1'b1;
                        end
                    end
                    OFF_SRC: if (!busy[wch]) src_r[wch] <= to_mem(wdata);
                    OFF_DST: if (!busy[wch]) dst_r[wch] <= to_mem(wdata);
                    OFF_LEN: if (!busy[wch]) len_r[wch] <= wdata;
                    default: ;
                endcase
            end
            if (wr_en && status_hit) begin
                done <= done & ~wdata[STATUS_DONE_LSB +: NUM_CH];
            end
            // Placed after the W1C so a simultaneous completion keeps DONE set.
            if (fin) begin
                busy[cur_ch] <= 1'b0;
                done[cur_ch] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            irq <= 1'b0;
        end else begin
            irq <= |(done & irq_en);
        end
    end

    // Transfer engine. Memory outputs are loaded on entry to RD_REQ/WR_REQ
    // and left untouched until the grant, which keeps them stable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cur_ch    <= '0;
            cur_src   <= '0;
            cur_dst   <= '0;
            rem       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|busy) begin
                        state <= ARB;
                    end
                end
                ARB: begin
                    if (|busy) begin
                        cur_ch  <= gnt_idx;
                        cur_src <= src_r[gnt_idx];
                        cur_dst <= dst_r[gnt_idx];
                        if (len_r[gnt_idx] == '0) begin
                            rem   <= '0;
                            state <= NEXT;
                        end else begin
                            rem      <= len_r[gnt_idx];
                            mem_req  <= 1'b1;
                            mem_we   <= 1'b0;
                            mem_addr <= src_r[gnt_idx];
                            state    <= RD_REQ;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                RD_REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state   <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (mem_rvalid) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= cur_dst;
                        mem_wdata <= mem_rdata;
                        state     <= WR_REQ;
                    end
                end
                WR_REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= NEXT;
                    end
                end
                NEXT: begin
                    cur_src <= cur_src + MEM_AW'(STEP);
                    cur_dst <= cur_dst + MEM_AW'(STEP);
                    if (rem != '0) begin
                        rem <= rem - DATA_WIDTH'(1);
                    end
                    if (rem_last) begin
                        state <= IDLE;
                    end else begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= cur_src + MEM_AW'(STEP);
                        state    <= RD_REQ;
                    end
                end
                default: begin
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_multi_ch_ctrl.sv
module tb_dma_multi_ch_ctrl;

    localparam int DW  = 32;
    localparam int AW  = 8;
    localparam int MAW = 32;
    localparam int NCH = 4;
    localparam logic [AW-1:0] STATUS = 8'h80;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           wr_en, rd_en;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  wdata, rdata;
    logic           mem_req, mem_we;
    logic [MAW-1:0] mem_addr;
    logic [DW-1:0]  mem_wdata;
    logic           mem_gnt, mem_rvalid;
    logic [DW-1:0]  mem_rdata;
    logic           irq;

    int checks = 0;
    int errors = 0;

    logic           gnt_en, rv_en, rd_pend;
    logic [MAW-1:0] pend_addr;
    logic [MAW-1:0] rd_log [$];
    logic [MAW-1:0] wr_log [$];
    logic [DW-1:0]  wd_log [$];
    int             req_cycles = 0;

    always #5 clk = ~clk;
    assign mem_gnt = gnt_en;

    dma_multi_ch_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .MEM_AW     (MAW),
        .NUM_CH     (NCH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .irq        (irq)
    );

    function automatic logic [DW-1:0] mdata(input logic [MAW-1:0] a);
        return 32'hA500_0000 ^ a;
    endfunction

    function automatic logic [AW-1:0] ch_a(input int ch, input int off);
        return AW'(ch * 16 + off);
    endfunction

    // Memory model: logs granted requests, returns read data one cycle after
    // the read grant (or later, once rv_en is raised).
    always @(posedge clk) begin
        mem_rvalid <= 1'b0;
        if (!rst_n) begin
            rd_pend <= 1'b0;
        end else begin
            if (mem_req) req_cycles <= req_cycles + 1;
            if (mem_req && mem_gnt && !mem_we) begin
                rd_log.push_back(mem_addr);
                if (rv_en) begin
                    mem_rvalid <= 1'b1;
                    mem_rdata  <= mdata(mem_addr);
                end else begin
                    rd_pend   <= 1'b1;
                    pend_addr <= mem_addr;
                end
            end else if (rd_pend && rv_en) begin
                mem_rvalid <= 1'b1;
                mem_rdata  <= mdata(pend_addr);
                rd_pend    <= 1'b0;
            end
            if (mem_req && mem_gnt && mem_we) begin
                wr_log.push_back(mem_addr);
                wd_log.push_back(mem_wdata);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        addr  = a;
        wdata = d;
        wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a, output logic [DW-1:0] d);
        addr  = a;
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        d = rdata;
    endtask

    task automatic wait_status(input logic [DW-1:0] mask, input logic [DW-1:0] val,
                               input string tag);
        logic [DW-1:0] v;
        logic          ok;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            rd(STATUS, v);
            if ((v & mask) == val) ok = 1'b1;
        end
        chk(tag, 64'(ok), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] v;
        int rb, wb, rq;
        logic found;

        rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wdata = '0;
        gnt_en = 1'b1; rv_en = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        chk("rst_rdata", rdata, 0);
        chk("rst_irq", irq, 0);
        chk("rst_mem_req", mem_req, 0);
        rd(STATUS, v);          chk("rst_status", v, 0);
        rd(ch_a(2, 4), v);      chk("rst_src2", v, 0);

        // Register write/readback, ch0 and ch3
        wr(ch_a(0, 4), 32'h1000); wr(ch_a(0, 8), 32'h2000);
        wr(ch_a(0, 12), 32'd5);   wr(ch_a(0, 0), 32'h2);
        wr(ch_a(3, 4), 32'h1000); wr(ch_a(3, 8), 32'h3000);
        wr(ch_a(3, 12), 32'd7);   wr(ch_a(3, 0), 32'h3 & 32'h2);
        rd(ch_a(0, 4), v);  chk("ch0_src", v, 32'h1000);
        rd(ch_a(0, 8), v);  chk("ch0_dst", v, 32'h2000);
        rd(ch_a(0, 12), v); chk("ch0_len", v, 32'd5);
        rd(ch_a(0, 0), v);  chk("ch0_ctrl", v, 32'h2);
        rd(ch_a(3, 4), v);  chk("ch3_src", v, 32'h1000);
        rd(ch_a(3, 8), v);  chk("ch3_dst", v, 32'h3000);
        rd(ch_a(3, 12), v); chk("ch3_len", v, 32'd7);
        @(negedge clk);
        chk("rdata_hold", rdata, 32'd7);
        rd(8'h90, v);       chk("unmapped_90", v, 0);
        rd(8'h40, v);       chk("unmapped_ch4", v, 0);
        // Simultaneous write and read returns the old value
        addr = ch_a(0, 8); wdata = 32'h2222; wr_en = 1'b1; rd_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0;
        chk("wr_rd_same_cycle", rdata, 32'h2000);
        rd(ch_a(0, 8), v);  chk("ch0_dst_new", v, 32'h2222);

        // ch1 three-word transfer with IRQ_EN
        rb = rd_log.size(); wb = wr_log.size();
        wr(ch_a(1, 4), 32'h100); wr(ch_a(1, 8), 32'h200);
        wr(ch_a(1, 12), 32'd3);  wr(ch_a(1, 0), 32'h3);
        wait_status(32'h0000_020F, 32'h0000_0200, "ch1_done_wait");
        rd(STATUS, v);      chk("ch1_status", v, 32'h0200);
        chk("ch1_irq", irq, 1);
        chk("ch1_nrd", rd_log.size(), rb + 3);
        chk("ch1_nwr", wr_log.size(), wb + 3);
        for (int k = 0; k < 3; k++) begin
            chk("ch1_rd_addr", rd_log[rb+k], 32'h100 + 4 * k);
            chk("ch1_wr_addr", wr_log[wb+k], 32'h200 + 4 * k);
            chk("ch1_wr_data", wd_log[wb+k], mdata(32'h100 + 4 * k));
        end
        rd(ch_a(1, 4), v);  chk("ch1_src_kept", v, 32'h100);
        rd(ch_a(1, 0), v);  chk("ch1_ctrl_start0", v, 32'h2);
        wr(STATUS, 32'h0200);
        @(negedge clk);
        chk("ch1_irq_clr", irq, 0);
        rd(STATUS, v);      chk("ch1_status_clr", v, 0);

        // LEN=0 start on ch3
        wr(ch_a(3, 12), 32'd0);
        rq = req_cycles; rb = rd_log.size();
        wr(ch_a(3, 0), 32'h3);
        repeat (3) @(negedge clk);
        rd(STATUS, v);      chk("len0_done", v, 32'h0800);
        chk("len0_no_req", req_cycles, rq);
        chk("len0_irq", irq, 1);
        wr(STATUS, 32'h0800);
        @(negedge clk);
        chk("len0_irq_clr", irq, 0);
        rd(STATUS, v);      chk("len0_status_clr", v, 0);

        // Grant stall on ch2
        gnt_en = 1'b0;
        wr(ch_a(2, 4), 32'h400); wr(ch_a(2, 8), 32'h600);
        wr(ch_a(2, 12), 32'd1);  wr(ch_a(2, 0), 32'h1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mem_req) found = 1'b1; else @(negedge clk);
        end
        chk("stall_req_seen", found, 1);
        for (int i = 0; i < 3; i++) begin
            chk("stall_req", mem_req, 1);
            chk("stall_addr", mem_addr, 32'h400);
            chk("stall_we", mem_we, 0);
            @(negedge clk);
        end
        wr(ch_a(2, 4), 32'hDEAD);
        chk("stall_addr_after_wr", mem_addr, 32'h400);
        rd(ch_a(2, 4), v);  chk("busy_src_ignored", v, 32'h400);
        chk("stall_addr_end", mem_addr, 32'h400);
        chk("stall_we_end", mem_we, 0);
        wb = wr_log.size();
        gnt_en = 1'b1;
        wait_status(32'h0000_0404, 32'h0000_0400, "ch2_done_wait");
        chk("ch2_wr_addr", wr_log[wb], 32'h600);
        chk("ch2_wr_data", wd_log[wb], mdata(32'h400));
        wr(STATUS, 32'h0400);

        // Round-robin: ch2 then ch0 started back-to-back, ch0 served first,
        // ch0 restarted while ch2 still waits -> ch2 next.
        wr(ch_a(0, 4), 32'h300); wr(ch_a(0, 8), 32'h310); wr(ch_a(0, 12), 32'd1);
        wr(ch_a(2, 4), 32'h500); wr(ch_a(2, 8), 32'h510); wr(ch_a(2, 12), 32'd1);
        rb = rd_log.size();
        wr(ch_a(2, 0), 32'h1);
        wr(ch_a(0, 0), 32'h1);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (mem_req && mem_we && mem_gnt && mem_addr == 32'h310) found = 1'b1;
            else @(negedge clk);
        end
        chk("rr_ch0_write_seen", found, 1);
        @(negedge clk);
        @(negedge clk);
        wr(ch_a(0, 0), 32'h1);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (rd_log.size() >= rb + 3) found = 1'b1; else @(negedge clk);
        end
        chk("rr_three_reads", found, 1);
        wait_status(32'h0000_00FF, 32'h0, "rr_idle_wait");
        chk("rr_first_ch0", rd_log[rb], 32'h300);
        chk("rr_then_ch2", rd_log[rb+1], 32'h500);
        chk("rr_then_ch0", rd_log[rb+2], 32'h300);
        rd(STATUS, v);      chk("rr_status", v, 32'h0500);
        chk("rr_irq_disabled", irq, 0);
        wr(STATUS, 32'h0500);

        // Reset during RD_WAIT
        rv_en = 1'b0;
        rb = rd_log.size();
        wr(ch_a(1, 4), 32'h700); wr(ch_a(1, 8), 32'h780);
        wr(ch_a(1, 12), 32'd2);  wr(ch_a(1, 0), 32'h1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (rd_log.size() == rb + 1) found = 1'b1; else @(negedge clk);
        end
        chk("rst_mid_read_granted", found, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rv_en = 1'b1;
        chk("rst_mid_mem_req", mem_req, 0);
        chk("rst_mid_rdata", rdata, 0);
        rq = req_cycles;
        rd(STATUS, v);      chk("rst_mid_status", v, 0);
        rd(ch_a(1, 4), v);  chk("rst_mid_src1", v, 0);
        repeat (3) @(negedge clk);
        chk("rst_mid_no_req", req_cycles, rq);
        rb = rd_log.size(); wb = wr_log.size();
        wr(ch_a(1, 4), 32'h700); wr(ch_a(1, 8), 32'h780);
        wr(ch_a(1, 12), 32'd2);  wr(ch_a(1, 0), 32'h1);
        wait_status(32'h0000_0202, 32'h0000_0200, "post_rst_done_wait");
        chk("post_rst_nrd", rd_log.size(), rb + 2);
        chk("post_rst_rd0", rd_log[rb], 32'h700);
        chk("post_rst_rd1", rd_log[rb+1], 32'h704);
        chk("post_rst_wr0", wr_log[wb], 32'h780);
        chk("post_rst_wr1", wr_log[wb+1], 32'h784);
        chk("post_rst_wd1", wd_log[wb+1], mdata(32'h704));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dma_multi_ch_ctrl.md
DMA_MULTI_CH_CTRL -- requirements
Module: dma_multi_ch_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of register data and memory data.
REQ-002 Parameter ADDR_WIDTH, default 8: width of the register-bus byte address.
REQ-003 Parameter MEM_AW, default 32: width of the memory-port byte address.
REQ-004 Parameter NUM_CH, default 4, range 1..8: number of DMA channels.
REQ-005 Port clk  in  1: single clock; all logic SHALL be clocked on its rising edge.
REQ-006 Port rst_n  in  1: reset, synchronous and active-low.
REQ-007 Port wr_en  in  1: register write strobe.
REQ-008 Port rd_en  in  1: register read strobe.
REQ-009 Port addr  in  ADDR_WIDTH: register byte address.
REQ-010 Port wdata  in  DATA_WIDTH: register write data.
REQ-011 Port rdata  out  DATA_WIDTH: register read data.
REQ-012 Port mem_req  out  1 / mem_we out 1 / mem_addr out MEM_AW / mem_wdata out DATA_WIDTH: memory request.
REQ-013 Port mem_gnt  in  1 / mem_rvalid in 1 / mem_rdata in DATA_WIDTH: memory grant, read return and read data.
REQ-014 Port irq  out  1: level interrupt.

Function
REQ-015 Per-channel registers SHALL sit at byte offset ch*0x10: CTRL 0x0 (bit0 START, bit1 IRQ_EN), SRC 0x4, DST 0x8, LEN 0xC (word count).
REQ-016 STATUS at 0x80 SHALL read as {DONE[NUM_CH-1:0] at bits 15:8, BUSY[NUM_CH-1:0] at bits 7:0}; writing 1 to a DONE bit SHALL clear it.
REQ-017 A read SHALL update rdata one cycle after rd_en; rdata SHALL hold between reads; unmapped addresses SHALL read 0.
REQ-018 A write SHALL take effect at the clock edge where wr_en is sampled high; simultaneous wr_en and rd_en SHALL return the pre-write value.
REQ-019 Writing START=1 SHALL set BUSY[ch]; START SHALL read as 0; writes to SRC/DST/LEN/START of a BUSY channel SHALL be ignored; IRQ_EN is always writable.
REQ-020 A single shared engine SHALL serve BUSY channels with round-robin arbitration, starting after the last served channel.
REQ-021 The engine FSM states SHALL be IDLE, ARB, RD_REQ, RD_WAIT, WR_REQ, NEXT.
REQ-022 IDLE->ARB when any BUSY is set. ARB latches the channel's SRC/DST/LEN and then goes to RD_REQ, or to NEXT if LEN==0.
REQ-023 RD_REQ: mem_req=1, mem_we=0, mem_addr=src; on mem_gnt go to RD_WAIT.
REQ-024 RD_WAIT: on mem_rvalid capture mem_rdata and go to WR_REQ.
REQ-025 WR_REQ: mem_req=1, mem_we=1, mem_addr=dst, mem_wdata=captured data; on mem_gnt go to NEXT.
REQ-026 NEXT: src += DATA_WIDTH/8 and dst += DATA_WIDTH/8, both wrapping modulo 2^MEM_AW; remaining -= 1. If remaining==0 (or LEN was 0): clear BUSY, set DONE, go to IDLE; otherwise go to RD_REQ.
REQ-027 The engine SHALL transfer one whole channel before re-arbitrating; SRC/DST/LEN registers SHALL keep their programmed values.
REQ-028 mem_req, mem_addr, mem_we and mem_wdata SHALL hold stable while mem_req=1 and mem_gnt=0.
REQ-029 irq SHALL equal OR over ch of (DONE[ch] & IRQ_EN[ch]), registered.
REQ-030 A DONE clear and a DONE set on the same cycle SHALL leave DONE set.

Reset
REQ-031 When rst_n=0 at a clock edge, all registers, BUSY, DONE, rdata, irq, mem_req, mem_we, mem_addr and mem_wdata SHALL become 0, the FSM SHALL return to IDLE, and the round-robin pointer SHALL be cleared.
REQ-032 A reset in the middle of a transfer SHALL abort it: mem_req=0 from the first cycle after reset, with no DONE bit set.

Structure
REQ-033 A shared package dma_pkg SHALL hold the engine state enum, the register-offset constants and the STATUS address.
REQ-034 The round-robin arbiter SHALL be a sub-module dma_rr_arb (NUM_CH request vector in, one-hot grant out, pointer update on an accept strobe).

Verification
REQ-035 Write/read each register of ch0 and ch3 (SRC=0x1000) -> SRC reads 0x1000 one cycle after rd_en; CTRL reads with START=0.
REQ-036 ch1 SRC=0x100, DST=0x200, LEN=3, mem_gnt=1, 1-cycle rvalid -> reads at 0x100/0x104/0x108, writes at 0x200/0x204/0x208 with matching data; DONE[1]=1; irq=1 if IRQ_EN set.
REQ-037 ch0 and ch2 started on the same cycle -> ch0 completes fully, then ch2 starts; a next request by both -> ch2 wins.
REQ-038 LEN=0 start -> no mem_req; DONE set within 4 cycles; W1C to DONE clears it and irq falls.
REQ-039 mem_gnt held low for 5 cycles -> mem_addr/mem_we stable throughout; SRC write during BUSY ignored.
REQ-040 rst_n=0 asserted during RD_WAIT -> mem_req=0, BUSY=0 and DONE=0 on the next cycle; a new start after reset operates normally.
